tag_nios_system_sysid_checker: RTL and testbench

Avalon-MM master that sits directly downstream of the system-ID slave and consumes its readdata. On start it reads word 0 (system ID) and word 1 (build timestamp), checks them against expected values, and latches a pass/fail verdict plus the captured values. Software and the boot-hold logic use this verdict to confirm that the loaded FPGA image matches the software build.

---
 rtl/tag_nios_system_sysid_checker.sv | 197 +++++++++++++++++++
 tb/tb_tag_nios_system_sysid_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_nios_system_sysid_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tag_nios_system_sysid_checker                                     |
// | Reads system-ID word 0 and build timestamp word 1, latches pass/fail.      |
// | Option : SYSID_CHECK_AUTOSTART_EN runs one check after every reset.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tag_nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] MIN_TIMESTAMP  = 32'd1618194548,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] id_q,
    output logic [31:0] ts_q,
    output logic [2:0]  retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_ID = 3'd1,
        S_RD_TS = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] c_TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] c_MAX_RETRY = 3'(MAX_RETRIES);
    localparam logic [1:0] c_FC_NONE   = 2'b00;
    localparam logic [1:0] c_FC_ID     = 2'b01;
    localparam logic [1:0] c_FC_TS     = 2'b10;
    localparam logic [1:0] c_FC_TO     = 2'b11;

    state_t      r_state, w_state;
    logic        r_gap, w_gap;
    logic [7:0]  r_to_cnt, w_to_cnt;
    logic [2:0]  r_retry, w_retry;
    logic        r_read, w_read;
    logic        r_addr, w_addr;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_pass, w_pass;
    logic [1:0]  r_fc, w_fc;
    logic [31:0] r_id, w_id;
    logic [31:0] r_ts, w_ts;
    logic        w_start;
    logic        w_xfer;
    logic        w_stall;

`ifdef SYSID_CHECK_AUTOSTART_EN
    // Armed by reset, consumed on the first edge after release.
    logic r_armed;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_armed <= 1'b1;
        else          r_armed <= 1'b0;
    end
    assign w_start = start | r_armed;
`else
    assign w_start = start;
`endif

    assign w_xfer  = r_read & ~avm_waitrequest;
    assign w_stall = r_read &  avm_waitrequest;

    always_comb begin
        w_state  = r_state;
        w_gap    = r_gap;
        w_to_cnt = r_to_cnt;
        w_retry  = r_retry;
        w_read   = r_read;
        w_addr   = r_addr;
        w_busy   = r_busy;
        w_done   = r_done;
        w_pass   = r_pass;
        w_fc     = r_fc;
        w_id     = r_id;
        w_ts     = r_ts;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_state  = S_RD_ID;
                    w_read   = 1'b1;
                    w_addr   = 1'b0;
                    w_gap    = 1'b0;
                    w_done   = 1'b0;
                    w_pass   = 1'b0;
                    w_fc     = c_FC_NONE;
                    w_retry  = 3'd0;
                    w_to_cnt = 8'd0;
                    w_busy   = 1'b1;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (r_gap) begin
                    // Address moves only while the strobe is low.
                    w_read = 1'b1;
                    w_addr = (r_state == S_RD_TS);
                    w_gap  = 1'b0;
                end else if (w_xfer) begin
                    w_read   = 1'b0;
                    w_to_cnt = 8'd0;
                    if (r_state == S_RD_ID) begin
                        w_id    = avm_readdata;
                        w_state = S_RD_TS;
                        w_gap   = 1'b1;
                    end else begin
                        w_ts    = avm_readdata;
                        w_state = S_EVAL;
                    end
                end else if (w_stall) begin
                    if (r_to_cnt == c_TO_LAST) begin
                        w_read   = 1'b0;
                        w_to_cnt = 8'd0;
                        if (r_retry < c_MAX_RETRY) begin
                            w_retry = r_retry + 3'd1;
                            w_state = S_RD_ID;
                            w_gap   = 1'b1;
                        end else begin
                            w_fc    = c_FC_TO;
                            w_state = S_DONE;
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                        end
                    end else begin
                        w_to_cnt = r_to_cnt + 8'd1;
                    end
                end
            end
            S_EVAL: begin
                if (r_id != EXPECTED_ID)       w_fc   = c_FC_ID;
                else if (r_ts < MIN_TIMESTAMP) w_fc   = c_FC_TS;
                else                           w_pass = 1'b1;
                w_state = S_DONE;
                w_done  = 1'b1;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_read  = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_gap    <= 1'b0;
            r_to_cnt <= 8'd0;
            r_retry  <= 3'd0;
            r_read   <= 1'b0;
            r_addr   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fc     <= 2'b00;
            r_id     <= 32'd0;
            r_ts     <= 32'd0;
        end else begin
            r_state  <= w_state;
            r_gap    <= w_gap;
            r_to_cnt <= w_to_cnt;
            r_retry  <= w_retry;
            r_read   <= w_read;
            r_addr   <= w_addr;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_pass   <= w_pass;
            r_fc     <= w_fc;
            r_id     <= w_id;
            r_ts     <= w_ts;
        end
    end

    assign avm_address = r_addr;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fc;
    assign id_q        = r_id;
    assign ts_q        = r_ts;
    assign retry_cnt   = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_tag_nios_system_sysid_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_tag_nios_system_sysid_checker                                  |
// | Scoreboard bench for the sysid checker against a small sysid slave model.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tag_nios_system_sysid_checker;

    localparam logic [31:0] MIN_TS = 32'd1618194548;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] id_q, ts_q;
    logic [2:0]  retry_cnt;

    logic [31:0] slv_id = 32'd0;
    logic [31:0] slv_ts = MIN_TS;
    logic        wr_hold = 1'b0;
    int          stall_base = 0;
    int          stall_n = 0;
    int          read_cycles = 0;

    typedef struct packed {
        logic        pass;
        logic [1:0]  fc;
        logic [31:0] id;
        logic [31:0] ts;
        logic [2:0]  retry;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    tag_nios_system_sysid_checker #(
        .EXPECTED_ID    (32'd0),
        .MIN_TIMESTAMP  (MIN_TS),
        .TIMEOUT_CYCLES (4),
        .MAX_RETRIES    (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .fail_code       (fail_code),
        .id_q            (id_q),
        .ts_q            (ts_q),
        .retry_cnt       (retry_cnt)
    );

    always #5 clock = ~clock;

    // Sysid slave model: combinational data, optional stall window.
    assign avm_readdata    = avm_address ? slv_ts : slv_id;
    assign avm_waitrequest = wr_hold || ((read_cycles - stall_base) < stall_n);

    always @(posedge clock) if (avm_read) read_cycles <= read_cycles + 1;

    function automatic exp_t got_verdict();
        got_verdict = '{pass, fail_code, id_q, ts_q, retry_cnt};
    endfunction

    task automatic run_seq(input int hold, input int limit, output int edges, output bit ok);
        @(negedge clock);
        start = 1'b1;
        repeat (hold) @(negedge clock);
        start = 1'b0;
        edges = hold;
        ok = 1'b0;
        while (edges <= limit && !ok) begin
            if (done === 1'b1) ok = 1'b1;
            else begin
                @(negedge clock);
                edges++;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic after_release(input string tag);
        bit   ok;
        exp_t e, g;
`ifdef SYSID_CHECK_AUTOSTART_EN
        sbq.push_back('{1'b1, 2'b00, slv_id, slv_ts, 3'd0});
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_autostart_busy: got %b expected 1", tag, busy);
        end
        wait_done(40, ok);
        e = sbq.pop_front();
        g = got_verdict();
        checks++;
        if (!ok || g !== e) begin
            errors++;
            $display("FAIL %s_autostart_verdict: done=%b got %h expected %h", tag, ok, g, e);
        end
`else
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, done, avm_read} !== 3'b000) begin
            errors++;
            $display("FAIL %s_stays_idle: got busy/done/read=%b expected 000", tag, {busy, done, avm_read});
        end
`endif
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++;
        if ({avm_address, avm_read, busy, done, pass, fail_code, id_q, ts_q, retry_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h fc=%b flags=%b expected all zero",
                     id_q, ts_q, fail_code, {avm_address, avm_read, busy, done, pass});
        end
        reset_n = 1'b1;
        after_release("reset");
    endtask

    task automatic test_pass;
        int edges; bit ok; exp_t e, g;
        slv_id = 32'd0; slv_ts = MIN_TS;
        sbq.push_back('{1'b1, 2'b00, 32'd0, MIN_TS, 3'd0});
        run_seq(1, 20, edges, ok);
        e = sbq.pop_front();
        g = got_verdict();
        checks++;
        if (!ok || g !== e) begin
            errors++;
            $display("FAIL pass_verdict: got %h expected %h", g, e);
        end
        checks++;
        if (edges !== 5) begin
            errors++;
            $display("FAIL pass_latency: got %0d edges expected 5", edges);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pass_busy_low: got %b expected 0", busy);
        end
    endtask

    task automatic test_verdicts;
        logic [31:0] ids[4] = '{32'd1, 32'd0, 32'd0, 32'd1};
        logic [31:0] tss[4] = '{MIN_TS, MIN_TS - 32'd1, 32'hFFFF_FFFF, 32'd0};
        logic [1:0]  fcs[4] = '{2'b01, 2'b10, 2'b00, 2'b01};
        int edges; bit ok; exp_t e, g;
        // Last entry leaves id_q=0, ts_q=max for the timeout test below.
        for (int i = 0; i < 4; i++) begin
            slv_id = ids[(i + 3) % 4 == 2 ? 3 : i];
            slv_ts = tss[(i + 3) % 4 == 2 ? 3 : i];
            if (i == 3) begin slv_id = 32'd0; slv_ts = 32'hFFFF_FFFF; end
            sbq.push_back('{(i == 3) || (i == 2) ? 1'b1 : 1'b0,
                            (i == 3) ? 2'b00 : fcs[i], slv_id, slv_ts, 3'd0});
            run_seq(1, 20, edges, ok);
            e = sbq.pop_front();
            g = got_verdict();
            checks++;
            if (!ok || g !== e) begin
                errors++;
                $display("FAIL verdict_%0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    task automatic test_timeout;
        int edges, base; bit ok; exp_t e, g;
        slv_id = 32'd5; slv_ts = 32'd7;
        wr_hold = 1'b1;
        base = read_cycles;
        sbq.push_back('{1'b0, 2'b11, 32'd0, 32'hFFFF_FFFF, 3'd2});
        run_seq(1, 60, edges, ok);
        wr_hold = 1'b0;
        e = sbq.pop_front();
        g = got_verdict();
        checks++;
        if (!ok || g !== e) begin
            errors++;
            $display("FAIL timeout_verdict: got %h expected %h", g, e);
        end
        checks++;
        if (read_cycles - base !== 12) begin
            errors++;
            $display("FAIL timeout_read_cycles: got %0d expected 12", read_cycles - base);
        end
        checks++;
        if (edges !== 15) begin
            errors++;
            $display("FAIL timeout_latency: got %0d edges expected 15", edges);
        end
    endtask

    task automatic test_stall_recover;
        int edges; bit ok; exp_t e, g;
        slv_id = 32'd0; slv_ts = MIN_TS + 32'd5;
        stall_base = read_cycles;
        stall_n = 3;
        sbq.push_back('{1'b1, 2'b00, 32'd0, MIN_TS + 32'd5, 3'd0});
        run_seq(1, 30, edges, ok);
        stall_n = 0;
        e = sbq.pop_front();
        g = got_verdict();
        checks++;
        if (!ok || g !== e) begin
            errors++;
            $display("FAIL stall_verdict: got %h expected %h", g, e);
        end
        checks++;
        if (edges !== 8) begin
            errors++;
            $display("FAIL stall_latency: got %0d edges expected 8", edges);
        end
    endtask

    task automatic test_back_to_back;
        int edges, base; bit ok; exp_t e, g;
        slv_id = 32'd0; slv_ts = MIN_TS;
        base = read_cycles;
        sbq.push_back('{1'b1, 2'b00, 32'd0, MIN_TS, 3'd0});
        run_seq(4, 20, edges, ok);
        repeat (4) @(negedge clock);
        e = sbq.pop_front();
        g = got_verdict();
        checks++;
        if (!ok || g !== e || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_verdict: got %h done=%b busy=%b expected %h done=1 busy=0", g, done, busy, e);
        end
        checks++;
        if (read_cycles - base !== 2) begin
            errors++;
            $display("FAIL b2b_single_sequence: got %0d read cycles expected 2", read_cycles - base);
        end
    endtask

    task automatic test_done_restart;
        bit ok; exp_t e, g;
        slv_id = 32'd0; slv_ts = MIN_TS + 32'd1;
        sbq.push_back('{1'b1, 2'b00, 32'd0, MIN_TS + 32'd1, 3'd0});
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        checks++;
        if ({done, busy, pass} !== 3'b010) begin
            errors++;
            $display("FAIL restart_clears: got done/busy/pass=%b expected 010", {done, busy, pass});
        end
        wait_done(20, ok);
        e = sbq.pop_front();
        g = got_verdict();
        checks++;
        if (!ok || g !== e) begin
            errors++;
            $display("FAIL restart_verdict: got %h expected %h", g, e);
        end
    endtask

    task automatic test_reset_mid;
        slv_id = 32'd0; slv_ts = MIN_TS;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({avm_read, avm_address} !== 2'b11) begin
            errors++;
            $display("FAIL mid_in_rd_ts: got read/addr=%b expected 11", {avm_read, avm_address});
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({avm_address, avm_read, busy, done, pass, fail_code, id_q, ts_q, retry_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got id=%h ts=%h fc=%b flags=%b expected all zero",
                     id_q, ts_q, fail_code, {avm_address, avm_read, busy, done, pass});
        end
        @(negedge clock);
        reset_n = 1'b1;
        after_release("mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pass();
        test_verdicts();
        test_timeout();
        test_stall_recover();
        test_back_to_back();
        test_done_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
